anim_scheduler: RTL and testbench

Request scheduler for the three-animal dot-matrix animation. It detects rising edges on the cat/dog/mouse buttons and keeps them as pending requests. When several requests are pending it grants them round-robin, then steps the granted animal through its four frames. It drives the 4-bit `mode` word {animal, frame} consumed by the dot-matrix driver and owns the per-animal left/right position state.

---
 rtl/anim_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_anim_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/anim_scheduler.sv
// anim_scheduler: round-robin request scheduler for the cat/dog/mouse
// dot-matrix animation. Detects button rising edges, queues them as pending
// requests, grants one at a time and steps the granted animal through its
// four frames, driving mode = {animal, frame} and the per-animal side state.
//
// Build option: ANIM_SCHED_QUEUE_EN
//   defined   - edges arriving while busy are queued in the pending mask
//   undefined - edges arriving while busy are discarded and pulse drop
module anim_scheduler #(
    parameter int STEP_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic       clk1khz,
    input  logic       rst_n,
    input  logic       off,
    input  logic       cat,
    input  logic       dog,
    input  logic       mouse,
    output logic [3:0] mode,
    output logic       busy,
    output logic       done,
    output logic       drop,
    output logic [2:0] side
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [2:0]         w_in;
    logic [2:0]         r_in_q;
    logic [2:0]         w_edge;
    logic [2:0]         w_edge_acc;
    logic               w_edge_drop;

    logic [2:0]         r_pend;
    logic [1:0]         r_ptr;
    logic [1:0]         r_anim;
    logic [3:0]         r_mode;
    logic [2:0]         r_side;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_drop;

    logic               w_busy;
    logic               w_grant;
    logic [1:0]         w_gnt_idx;
    logic [2:0]         w_gnt_mask;
    logic [1:0]         w_ptr_after;
    logic [2:0]         w_anim_mask;
    logic               w_anim_side;
    logic               w_cnt_last;
    logic               w_frame_end;

    assign w_in   = {mouse, dog, cat};
    assign w_busy = (r_state != S_IDLE);

    // Per-animal rising-edge detect; edges are masked while off is asserted
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            assign w_edge[gi] = w_in[gi] & ~r_in_q[gi] & ~off;
        end
    endgenerate

`ifdef ANIM_SCHED_QUEUE_EN
    assign w_edge_acc  = w_edge;
    assign w_edge_drop = 1'b0;
`else
    assign w_edge_acc  = w_busy ? 3'b000 : w_edge;
    assign w_edge_drop = w_busy & (|w_edge);
`endif

    // Input history tracks the buttons even in reset/off, so a button held
    // through reset does not look like a fresh press afterwards
    always_ff @(posedge clk1khz) begin
        r_in_q <= w_in;
    end

    // Round-robin pick: first pending bit at or after the pointer
    always_comb begin
        w_gnt_idx = 2'd0;
        case (r_ptr)
            2'd1: begin
                if (r_pend[1])      w_gnt_idx = 2'd1;
                else if (r_pend[2]) w_gnt_idx = 2'd2;
                else                w_gnt_idx = 2'd0;
            end
            2'd2: begin
                if (r_pend[2])      w_gnt_idx = 2'd2;
                else if (r_pend[0]) w_gnt_idx = 2'd0;
                else                w_gnt_idx = 2'd1;
            end
            default: begin
                if (r_pend[0])      w_gnt_idx = 2'd0;
                else if (r_pend[1]) w_gnt_idx = 2'd1;
                else                w_gnt_idx = 2'd2;
            end
        endcase
    end

    assign w_grant     = (r_state == S_IDLE) && (|r_pend);
    assign w_gnt_mask  = 3'b001 << w_gnt_idx;
    assign w_ptr_after = (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;

    assign w_anim_mask = 3'b001 << r_anim;
    assign w_anim_side = |(r_side & w_anim_mask);
    assign w_cnt_last  = (r_cnt == CNT_W'(STEP_DIV - 1));
    // Right-side animals play backwards, so their last frame is 00
    assign w_frame_end = w_anim_side ? (r_mode[1:0] == 2'b00)
                                     : (r_mode[1:0] == 2'b11);

    // State register; reset and off both return to IDLE
    always_ff @(posedge clk1khz) begin
        if (!rst_n || off) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_state_next = S_LOAD;
            S_LOAD: w_state_next = S_STEP;
            S_STEP: if (w_cnt_last && w_frame_end) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: pending mask, pointer, frame counter, mode word and sides.
    // mode is written as a whole word so animal and frame never disagree.
    always_ff @(posedge clk1khz) begin
        if (!rst_n || off) begin
            r_pend <= 3'b000;
            r_anim <= 2'd0;
            r_mode <= 4'b1100;
            r_side <= 3'b000;
            r_cnt  <= '0;
            r_drop <= 1'b0;
            // off keeps the fairness pointer; only a true reset clears it
            if (!rst_n) begin
                r_ptr <= 2'd0;
            end
        end else begin
            r_drop <= w_edge_drop;
            // Grant clears first, then a same-cycle edge sets again (edge wins)
            r_pend <= (r_pend & ~(w_grant ? w_gnt_mask : 3'b000)) | w_edge_acc;
            if (w_grant) begin
                r_ptr  <= w_ptr_after;
                r_anim <= w_gnt_idx;
            end
            case (r_state)
                S_LOAD: begin
                    r_mode <= {r_anim, (w_anim_side ? 2'b11 : 2'b00)};
                    r_cnt  <= '0;
                end
                S_STEP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (w_frame_end) begin
                            r_side <= r_side ^ w_anim_mask;
                        end else if (w_anim_side) begin
                            r_mode <= {r_mode[3:2], r_mode[1:0] - 2'd1};
                        end else begin
                            r_mode <= {r_mode[3:2], r_mode[1:0] + 2'd1};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mode = r_mode;
    assign busy = w_busy;
    assign done = (r_state == S_DONE);
    assign drop = r_drop;
    assign side = r_side;

endmodule

// File: tb/tb_anim_scheduler.sv
// Directed testbench for anim_scheduler with STEP_DIV = 4.
module tb_anim_scheduler;

    logic       clk1khz = 1'b0;
    logic       rst_n   = 1'b0;
    logic       off     = 1'b0;
    logic       cat     = 1'b0;
    logic       dog     = 1'b0;
    logic       mouse   = 1'b0;
    logic [3:0] mode;
    logic       busy;
    logic       done;
    logic       drop;
    logic [2:0] side;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_side = 3'b000;

`ifdef ANIM_SCHED_QUEUE_EN
    localparam logic EXP_DROP = 1'b0;
`else
    localparam logic EXP_DROP = 1'b1;
`endif

    anim_scheduler #(.STEP_DIV(4), .CNT_W(3)) dut (
        .clk1khz (clk1khz),
        .rst_n   (rst_n),
        .off     (off),
        .cat     (cat),
        .dog     (dog),
        .mouse   (mouse),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .drop    (drop),
        .side    (side)
    );

    always #5 clk1khz = ~clk1khz;

    task automatic tick();
        @(posedge clk1khz);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_side = 3'b000;
        check("rst_mode", {4'h0, mode}, 8'h0c);
        check("rst_busy", {7'h0, busy}, 8'h00);
    endtask

    // Pulse buttons for one cycle; returns at the first frame-0 sample
    task automatic req(input logic [2:0] m);
        {mouse, dog, cat} = m;
        tick();
        {mouse, dog, cat} = 3'b000;
        check("req_idle", {7'h0, busy}, 8'h00);
        tick();
        check("load_busy", {7'h0, busy}, 8'h01);
        tick();
    endtask

    // From the IDLE gap sample, advance through LOAD to frame 0
    task automatic next_load();
        tick();
        check("b2b_load_busy", {7'h0, busy}, 8'h01);
        tick();
    endtask

    // Check all four frames, the done cycle and the IDLE cycle after it.
    // inj_f selects a frame at whose start inj_mask is pressed (4 = none).
    task automatic run_anim(input logic [1:0] a, input int inj_f,
                            input logic [2:0] inj_mask, input string tag);
        logic       rev;
        logic [1:0] fr;
        logic [1:0] last;
        rev  = exp_side[a];
        last = rev ? 2'b00 : 2'b11;
        for (int f = 0; f < 4; f++) begin
            fr = rev ? 2'(3 - f) : 2'(f);
            for (int j = 0; j < 4; j++) begin
                check({tag, "_mode"}, {4'h0, a, fr}, {4'h0, mode});
                if (f == inj_f && j == 0) begin
                    {mouse, dog, cat} = inj_mask;
                end
                if (f == inj_f && j == 1) begin
                    check({tag, "_drop_pulse"}, {7'h0, drop}, {7'h0, EXP_DROP});
                    {mouse, dog, cat} = 3'b000;
                end
                if (f == inj_f && j == 2) begin
                    check({tag, "_drop_end"}, {7'h0, drop}, 8'h00);
                end
                tick();
            end
        end
        exp_side[a] = ~exp_side[a];
        check({tag, "_done"}, {7'h0, done}, 8'h01);
        check({tag, "_done_mode"}, {4'h0, mode}, {4'h0, a, last});
        check({tag, "_side"}, {5'h0, side}, {5'h0, exp_side});
        check({tag, "_done_busy"}, {7'h0, busy}, 8'h01);
        tick();
        check({tag, "_idle_done"}, {7'h0, done}, 8'h00);
        check({tag, "_idle_busy"}, {7'h0, busy}, 8'h00);
        check({tag, "_idle_mode"}, {4'h0, mode}, {4'h0, a, last});
    endtask

    initial begin
        // 1. Reset with buttons held high
        {mouse, dog, cat} = 3'b111;
        rst_n = 1'b0;
        tick();
        tick();
        check("t1_mode", {4'h0, mode}, 8'h0c);
        check("t1_busy", {7'h0, busy}, 8'h00);
        check("t1_side", {5'h0, side}, 8'h00);
        check("t1_done", {7'h0, done}, 8'h00);
        check("t1_drop", {7'h0, drop}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_no_grant", {7'h0, busy}, 8'h00);
        end
        {mouse, dog, cat} = 3'b000;
        tick();

        // 2. Cat forward then reverse
        req(3'b001);
        run_anim(2'd0, 4, 3'b000, "t2_cat_fwd");
        req(3'b001);
        run_anim(2'd0, 4, 3'b000, "t2_cat_rev");

        // 3. Round-robin
        do_reset();
        req(3'b111);
        run_anim(2'd0, 4, 3'b000, "t3_cat");
        next_load();
        run_anim(2'd1, 4, 3'b000, "t3_dog");
        next_load();
        run_anim(2'd2, 4, 3'b000, "t3_mouse");
        req(3'b010);
        run_anim(2'd1, 4, 3'b000, "t3_dog2");
        req(3'b101);
        run_anim(2'd2, 4, 3'b000, "t3_mouse_first");
        next_load();
        run_anim(2'd0, 4, 3'b000, "t3_cat_second");

        // 4. Dog edge during cat frame 01
        req(3'b001);
        run_anim(2'd0, 1, 3'b010, "t4_cat");
`ifdef ANIM_SCHED_QUEUE_EN
        next_load();
        run_anim(2'd1, 4, 3'b000, "t4_dog_queued");
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_dog_dropped", {7'h0, busy}, 8'h00);
        end
`endif

        // 5. Abort with off while dog at frame 10 and mouse pending
        do_reset();
        req(3'b001);
        run_anim(2'd0, 4, 3'b000, "t5_cat");
        req(3'b110);
        for (int i = 0; i < 8; i++) tick();
        check("t5_pre_mode", {4'h0, mode}, 8'h06);
        off = 1'b1;
        tick();
        off = 1'b0;
        exp_side = 3'b000;
        check("t5_mode", {4'h0, mode}, 8'h0c);
        check("t5_busy", {7'h0, busy}, 8'h00);
        check("t5_side", {5'h0, side}, 8'h00);
        check("t5_done", {7'h0, done}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_pend", {6'h0, busy, done}, 8'h00);
        end
        req(3'b101);
        run_anim(2'd2, 4, 3'b000, "t5_mouse_ptr_kept");
        next_load();
        run_anim(2'd0, 4, 3'b000, "t5_cat");

        // 6. Reset in the middle of a cat animation
        req(3'b001);
        check("t6_start_mode", {4'h0, mode}, 8'h03);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        check("t6_mode", {4'h0, mode}, 8'h0c);
        check("t6_busy", {7'h0, busy}, 8'h00);
        check("t6_side", {5'h0, side}, 8'h00);
        check("t6_done", {7'h0, done}, 8'h00);
        check("t6_drop", {7'h0, drop}, 8'h00);
        rst_n = 1'b1;
        exp_side = 3'b000;
        tick();
        req(3'b011);
        run_anim(2'd0, 4, 3'b000, "t6_cat_first");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
